scm65_ff_array: RTL and testbench

//  Flip-flop based standard-cell memory (SCM) macro: the responder side of the scm65

---
 rtl/scm65_ff_array.sv | 98 +++++++++
 tb/tb_scm65_ff_array.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/scm65_ff_array.sv
`timescale 1ns/1ps
// scm65_ff_array: flip-flop based standard-cell memory with one write port and one read port.
// Writes pass through a single pipeline stage before committing to the array. Reads forward
// the pending write so they always see the newest captured data. SE=1 blocks new functional
// accesses, but a write already in the pipe still commits.
module scm65_ff_array #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_ROWS   = 64
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic [DATA_WIDTH-1:0] DOUT,
    input  logic [ADDR_WIDTH-1:0] RADDR,
    input  logic                  RE,
    input  logic                  SE,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic                  WE
);

    // Row index width; out-of-range addresses are filtered before indexing.
    localparam int IDXW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    logic                  r_wp_v;
    logic [ADDR_WIDTH-1:0] r_wp_addr;
    logic [DATA_WIDTH-1:0] r_wp_data;
    logic [DATA_WIDTH-1:0] r_dout;

    logic [DATA_WIDTH-1:0] w_rows [NUM_ROWS];
    logic [NUM_ROWS-1:0]   w_row_en;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rd_in_range;
    logic                  w_fwd_hit;

    // Write pipe: capture the write now; it commits to its row on the next edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wp_v    <= 1'b0;
            r_wp_addr <= '0;
            r_wp_data <= '0;
        end else if (WE && !SE) begin
            r_wp_v    <= 1'b1;
            r_wp_addr <= WADDR;
            r_wp_data <= DIN;
        end else begin
            r_wp_v    <= 1'b0;
        end
    end

    // Storage rows. Each row has its own enable, which maps onto a per-row clock gate.
    // An out-of-range pending address matches no row, so that commit is dropped.
    for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
        localparam logic [ADDR_WIDTH-1:0] ROW_ADDR = ADDR_WIDTH'(g);
        logic [DATA_WIDTH-1:0] r_row;

        assign w_row_en[g] = r_wp_v && (r_wp_addr == ROW_ADDR);
        assign w_rows[g]   = r_row;

        // Commit the pending write when this row is the target.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_row <= '0;
            end else if (w_row_en[g]) begin
                r_row <= r_wp_data;
            end
        end
    end

    assign w_fwd_hit     = r_wp_v && (r_wp_addr == RADDR);
    assign w_rd_in_range = (32'(RADDR) < 32'(NUM_ROWS));

    // Read word select. The pending write takes priority over the array, and
    // unimplemented addresses read as zero.
    always_comb begin
        w_rd_word = '0;
        if (w_fwd_hit) begin
            w_rd_word = r_wp_data;
        end else if (w_rd_in_range) begin
            w_rd_word = w_rows[RADDR[IDXW-1:0]];
        end
    end

    // Registered read data; it holds its value when there is no functional read.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_dout <= '0;
        end else if (RE && !SE) begin
            r_dout <= w_rd_word;
        end
    end

    assign DOUT = r_dout;

    // Enable inputs must be known whenever the macro is out of reset.
    a_no_x_ctrl : assert property (@(posedge CLK) disable iff (!RSTN) !$isunknown({RE, WE}));

endmodule

// File: tb/tb_scm65_ff_array.sv
`timescale 1ns/1ps
// Bench for scm65_ff_array built with 48 rows, so addresses 48..63 are unimplemented.
// Expected read data comes from a simple reference model of the memory's visible contents.
module tb_scm65_ff_array;

    localparam int AW = 6;
    localparam int DW = 64;
    localparam int NR = 48;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic [DW-1:0] DOUT;
    logic [AW-1:0] RADDR = '0;
    logic          RE = 1'b0;
    logic          SE = 1'b0;
    logic [AW-1:0] WADDR = '0;
    logic          WE = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model. A captured in-range write is visible from the next edge onward.
    // An out-of-range write is visible only to a read on the following edge, because the
    // pipe forwards it and then drops it.
    logic [DW-1:0] m_mem [2**AW];
    logic          m_prev_v;
    logic [AW-1:0] m_prev_a;
    logic [DW-1:0] m_prev_d;
    logic [DW-1:0] m_dout;

    scm65_ff_array #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ROWS(NR)) dut (
        .CLK(CLK), .RSTN(RSTN), .DIN(DIN), .DOUT(DOUT), .RADDR(RADDR),
        .RE(RE), .SE(SE), .WADDR(WADDR), .WE(WE)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
        m_prev_v = 1'b0;
        m_prev_a = '0;
        m_prev_d = '0;
        m_dout   = '0;
    endtask

    task automatic check(input string tag);
        checks++;
        assert (DOUT === m_dout) else begin
            errors++;
            $error("FAIL %s: DOUT=%h expected=%h", tag, DOUT, m_dout);
        end
    endtask

    // One clock cycle. Inputs are driven 1 ns before the edge, and DOUT is checked
    // 9 ns after the edge.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ra, input logic se,
                       input string tag);
        WE = we; WADDR = wa; DIN = d; RE = re; RADDR = ra; SE = se;
        @(posedge CLK);
        if (re && !se) begin
            if (int'(ra) < NR) m_dout = m_mem[ra];
            else               m_dout = (m_prev_v && m_prev_a == ra) ? m_prev_d : '0;
        end
        if (we && !se) begin
            if (int'(wa) < NR) m_mem[wa] = d;
            m_prev_v = 1'b1; m_prev_a = wa; m_prev_d = d;
        end else begin
            m_prev_v = 1'b0;
        end
        #9;
        check(tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, tag);
    endtask

    initial begin
        logic [DW-1:0] rd;
        model_reset();

        #12;
        check("reset_dout");
        RSTN = 1'b1;
        @(posedge CLK);
        #9;

        // T1: fill every implemented row, then issue random reads over the whole address space.
        for (int i = 0; i < NR; i++) begin
            rd = {$urandom(), $urandom()};
            cyc(1'b1, AW'(i), rd, 1'b0, '0, 1'b0, "fill");
        end
        for (int i = 0; i < 200; i++)
            cyc(1'b0, '0, '0, 1'b1, AW'($urandom_range(0, 2**AW-1)), 1'b0, "rand_read");

        // T2: a read on the edge after a write gets the forwarded data.
        cyc(1'b1, 6'd5, 64'hA5A5_0000_0000_5A5A, 1'b0, '0, 1'b0, "fwd_wr");
        cyc(1'b0, '0, '0, 1'b1, 6'd5, 1'b0, "fwd_rd");
        assert (DOUT === 64'hA5A5_0000_0000_5A5A) else begin
            errors++;
            $error("FAIL fwd_const: DOUT=%h expected=%h", DOUT, 64'hA5A5_0000_0000_5A5A);
        end
        checks++;

        // T3: a read and a write to the same address on one edge. The read returns the
        // old value; the new value is visible on the following edge.
        cyc(1'b1, 6'd9, 64'h1, 1'b0, '0, 1'b0, "col_pre");
        idle("col_idle");
        cyc(1'b1, 6'd9, 64'h2, 1'b1, 6'd9, 1'b0, "col_same_edge");
        cyc(1'b0, '0, '0, 1'b1, 6'd9, 1'b0, "col_next_edge");
        cyc(1'b0, '0, '0, 1'b1, 6'd9, 1'b0, "col_array");

        // T4: scan inhibit blocks new writes and freezes DOUT.
        cyc(1'b0, '0, '0, 1'b1, 6'd3, 1'b0, "scan_pre");
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 6'd3, 64'hFF, 1'b1, 6'd3, 1'b1, "scan_hold");
        cyc(1'b0, '0, '0, 1'b1, 6'd3, 1'b0, "scan_row3");
        cyc(1'b1, 6'd3, 64'hFF, 1'b0, '0, 1'b0, "scan_resume_wr");
        cyc(1'b0, '0, '0, 1'b1, 6'd3, 1'b0, "scan_resume_rd");

        // T4b: a write already in the pipe still commits while SE is asserted.
        cyc(1'b1, 6'd4, 64'h4444, 1'b0, '0, 1'b0, "scan_pipe_wr");
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, "scan_pipe_se");
        cyc(1'b0, '0, '0, 1'b1, 6'd4, 1'b0, "scan_pipe_rd");

        // T5: an out-of-range write is forwarded once and then reads as zero.
        cyc(1'b1, 6'd47, 64'hBEEF, 1'b0, '0, 1'b0, "range_wr47");
        cyc(1'b1, 6'd50, 64'hDEAD, 1'b0, '0, 1'b0, "range_wr50");
        cyc(1'b0, '0, '0, 1'b1, 6'd50, 1'b0, "range_fwd50");
        idle("range_idle");
        cyc(1'b0, '0, '0, 1'b1, 6'd50, 1'b0, "range_rd50");
        cyc(1'b0, '0, '0, 1'b1, 6'd47, 1'b0, "range_rd47");

        // Mixed random traffic: writes, reads and occasional scan-enable cycles.
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom(), $urandom()};
            cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 2**AW-1)), rd,
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 2**AW-1)),
                ($urandom_range(0, 7) == 0), "mixed");
        end

        // T6: reset arrives while a write is pending. DOUT clears at once, and the
        // pending write is lost.
        cyc(1'b0, '0, '0, 1'b1, 6'd47, 1'b0, "rst_pre_rd");
        WE = 1'b1; WADDR = 6'd7; DIN = 64'h7777; RE = 1'b1; RADDR = 6'd5; SE = 1'b0;
        @(posedge CLK);
        #1;
        RSTN = 1'b0;
        model_reset();
        #1;
        check("rst_async");
        #2;
        RSTN = 1'b1;
        WE = 1'b0; RE = 1'b0;
        #5;
        for (int i = 0; i < 2**AW; i++)
            cyc(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, "rst_rows");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety timeout so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
